store_buffer: RTL and testbench
===============================

# store_buffer

Parametrised multi-entry post-commit store buffer between the ROB commit point and the data-memory port. It accepts committed stores as address/data/byte-mask triples, drains them to memory in program order with a req/resp handshake, and answers load lookups with youngest-first, byte-granular forwarding. Its entries carry the same address/wdata/wmask triple as `store_buff_t`, generalised in depth and data width.

## Interface
- DEPTH, 4: number of entries; power of two, ≥2
- ADDR_W, 32: address width
- DATA_W, 32: data width; MASK_W = DATA_W/8; word offset bits OFF = $clog2(MASK_W)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- enq_valid  in  1  committed store offered
- enq_ready  out  1  buffer can accept
- enq_addr  in  ADDR_W  store address; low OFF bits ignored
- enq_wdata  in  DATA_W  lane-aligned store data
- enq_wmask  in  MASK_W  byte enables; never 0
- dmem_write  out  1  write request to memory
- dmem_addr  out  ADDR_W  head word address, low OFF bits 0
- dmem_wdata  out  DATA_W  head data
- dmem_wmask  out  MASK_W  head mask
- dmem_resp  in  1  write complete, 1-cycle pulse
- ld_valid  in  1  load lookup active
- ld_addr  in  ADDR_W  load address
- ld_rmask  in  MASK_W  bytes the load needs
- fwd_data  out  DATA_W  forwarded bytes; lanes outside fwd_mask are 0
- fwd_mask  out  MASK_W  lanes supplied by the buffer
- fwd_full  out  1  every ld_rmask lane is supplied
- fwd_partial  out  1  some, but not all, lanes supplied; load must stall
- count  out  $clog2(DEPTH+1)  occupied entries
- empty  out  1  count==0

## Operation
- Circular FIFO: head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH; per-entry valid bit.
- Enqueue when enq_valid && enq_ready. Entry stores the word address, data and mask at the tail; tail advances.
- enq_ready = (count < DEPTH), evaluated on current state. A pop in the same cycle does not free a slot for a same-cycle enqueue when the buffer is full.
- Drain FSM has two states:
  - IDLE: if count>0, go to WRITE next cycle; otherwise stay in IDLE.
  - WRITE: dmem_write=1 and dmem_* are driven from the head entry, held stable until dmem_resp. On dmem_resp the head is invalidated, head advances, and the FSM returns to IDLE.
  - dmem_resp while in IDLE is ignored.
- Simultaneous enqueue and pop: both take effect; count is unchanged.
- Forwarding is combinational and applies when ld_valid=1. An entry matches when its word address equals ld_addr[ADDR_W-1:OFF].
  - Per lane, the youngest matching entry with that mask bit set supplies the byte.
  - The in-flight head entry remains eligible until it is popped.
  - fwd_full = ld_valid && (ld_rmask & ~fwd_mask)==0 && ld_rmask!=0.
  - fwd_partial = ld_valid && (ld_rmask & fwd_mask)!=0 && !fwd_full.
  - When ld_valid=0, all fwd_* outputs are 0.

## Timing
- Reset values: enq_ready=1, dmem_write=0, dmem_addr/wdata/wmask=0, fwd_*=0, count=0, empty=1, FSM=IDLE, all entries invalid.
- Reset mid-write drops dmem_write immediately (async). A pending store is lost; the memory side must tolerate this.
- Enqueue accepted at edge N: entry is forwardable in cycle N+1; dmem_write first rises in cycle N+2 if the buffer was empty.
- Back-to-back drain: one IDLE bubble between writes. Throughput is one store per (memory latency + 2) cycles.
- count and empty are registered and update on the accepting edge.

## Configuration
- STORE_BUFFER_COALESCE_EN defined: an enqueue whose word address matches the youngest entry merges into that entry (mask OR; new data overwrites the enabled lanes) without allocating a slot.
  - Coalescing is disabled when the youngest entry is the head and FSM=WRITE.
  - A coalescible enqueue is accepted even when the buffer is full: enq_ready = !full || coalescible.
- Undefined: every accepted store allocates a new entry.

## Test plan
- Reset, then enqueue (0x100, 0xAABBCCDD, 4'b1111) at cycle 1 -> dmem_write in cycle 3 with addr 0x100; dmem_resp in cycle 5 -> empty=1 in cycle 6.
- Fill 4 entries with dmem_resp held 0 -> enq_ready=0, count=4. A fifth enq_valid is not accepted. Pulse dmem_resp -> count=3, enq_ready=1 next cycle. Pointer wrap checked across 10 enqueues.
- Enqueue (0x200, 0x11223344, 4'b0011), then (0x200, 0x55667788, 4'b0110); lookup 0x200 with rmask 4'b0111 -> fwd_data=0x00667744, fwd_full=1.
- Buffer holds (0x300, mask 4'b0001); lookup 0x300 with rmask 4'b0011 -> fwd_partial=1, fwd_full=0. Lookup 0x304 -> fwd_mask=0.
- With STORE_BUFFER_COALESCE_EN: two enqueues to 0x400 with masks 0001 and 0100 -> count=1, single dmem write with mask 0101. Without the macro: count=2, two writes.
- Assert rst during WRITE -> dmem_write=0 in the same cycle, count=0, enq_ready=1.

Source files
------------

// File: rtl/store_buffer.sv
// Post-commit store buffer: in-order drain to memory, youngest-first byte forwarding to loads.
// Optional feature: define STORE_BUFFER_COALESCE_EN to merge same-word stores into the youngest entry.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int MASK_W = DATA_W / 8,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [ADDR_W-1:0] enq_addr,
  input  logic [DATA_W-1:0] enq_wdata,
  input  logic [MASK_W-1:0] enq_wmask,
  output logic              dmem_write,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [MASK_W-1:0] dmem_wmask,
  input  logic              dmem_resp,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [MASK_W-1:0] ld_rmask,
  output logic [DATA_W-1:0] fwd_data,
  output logic [MASK_W-1:0] fwd_mask,
  output logic              fwd_full,
  output logic              fwd_partial,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              dbg_state
);

  localparam int OFF   = $clog2(MASK_W);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int WA_W  = ADDR_W - OFF;

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t            r_state, w_state_nxt;
  logic [WA_W-1:0]   r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [MASK_W-1:0] r_mask [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [PTR_W-1:0]  r_head, r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_empty;

  logic [WA_W-1:0]   w_enq_wa;
  logic              w_full, w_coal, w_enq, w_alloc, w_pop;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [MASK_W-1:0] w_fmask;
  logic [DATA_W-1:0] w_fdata;
  logic [PTR_W-1:0]  w_idx;
  logic              w_unused;

  // Handshakes: a store moves in on a cycle with enq_valid && enq_ready; a memory
  // write is outstanding while dmem_write=1 and completes on the dmem_resp pulse.
  assign w_enq_wa = enq_addr[ADDR_W-1:OFF];
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_pop    = (r_state == S_WRITE) && dmem_resp;
  assign w_unused = ^{enq_addr[OFF-1:0], ld_addr[OFF-1:0]};

`ifdef STORE_BUFFER_COALESCE_EN
  logic [PTR_W-1:0] w_yng;
  assign w_yng     = r_tail - PTR_W'(1);
  // The head being written must not change under the memory, so it is excluded.
  assign w_coal    = (r_count != '0) && (r_addr[w_yng] == w_enq_wa) &&
                     !((w_yng == r_head) && (r_state == S_WRITE));
  assign enq_ready = !w_full || w_coal;
`else
  assign w_coal    = 1'b0;
  assign enq_ready = !w_full;
`endif

  assign w_enq       = enq_valid && enq_ready;
  assign w_alloc     = w_enq && !w_coal;
  assign w_count_nxt = r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_mask[i] <= '0;
      end
      r_vld   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
    end else begin
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PTR_W'(1);
      end
      if (w_alloc) begin
        r_vld[r_tail]  <= 1'b1;
        r_addr[r_tail] <= w_enq_wa;
        r_data[r_tail] <= enq_wdata;
        r_mask[r_tail] <= enq_wmask;
        r_tail         <= r_tail + PTR_W'(1);
      end
`ifdef STORE_BUFFER_COALESCE_EN
      if (w_enq && w_coal) begin
        r_mask[w_yng] <= r_mask[w_yng] | enq_wmask;
        for (int b = 0; b < MASK_W; b++)
          if (enq_wmask[b]) r_data[w_yng][8*b +: 8] <= enq_wdata[8*b +: 8];
      end
`endif
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_count != '0) w_state_nxt = S_WRITE;
      S_WRITE: if (dmem_resp)     w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign dmem_write = (r_state == S_WRITE);
  assign dmem_addr  = dmem_write ? {r_addr[r_head], {OFF{1'b0}}} : '0;
  assign dmem_wdata = dmem_write ? r_data[r_head] : '0;
  assign dmem_wmask = dmem_write ? r_mask[r_head] : '0;
  assign count      = r_count;
  assign empty      = r_empty;
  assign dbg_state  = (r_state == S_WRITE);

  // Walk oldest to youngest so later matches overwrite earlier ones per lane.
  always_comb begin
    w_fmask = '0;
    w_fdata = '0;
    w_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + PTR_W'(k);
      if (r_vld[w_idx] && (r_addr[w_idx] == ld_addr[ADDR_W-1:OFF])) begin
        for (int b = 0; b < MASK_W; b++) begin
          if (r_mask[w_idx][b]) begin
            w_fmask[b]         = 1'b1;
            w_fdata[8*b +: 8]  = r_data[w_idx][8*b +: 8];
          end
        end
      end
    end
  end

  assign fwd_mask    = ld_valid ? w_fmask : '0;
  assign fwd_data    = ld_valid ? w_fdata : '0;
  assign fwd_full    = ld_valid && ((ld_rmask & ~w_fmask) == '0) && (ld_rmask != '0);
  assign fwd_partial = ld_valid && ((ld_rmask & w_fmask) != '0) && !fwd_full;

endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int E_W   = 66;  // {word addr[29:0], data[31:0], mask[3:0]}
`ifdef STORE_BUFFER_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic        clk, rst;
  logic        enq_valid, enq_ready;
  logic [31:0] enq_addr, enq_wdata;
  logic [3:0]  enq_wmask;
  logic        dmem_write, dmem_resp;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wmask;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [3:0]  ld_rmask;
  logic [31:0] fwd_data;
  logic [3:0]  fwd_mask;
  logic        fwd_full, fwd_partial;
  logic [2:0]  count;
  logic        empty, dbg_state;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_addr(enq_addr),
    .enq_wdata(enq_wdata), .enq_wmask(enq_wmask),
    .dmem_write(dmem_write), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wmask(dmem_wmask), .dmem_resp(dmem_resp),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_rmask(ld_rmask),
    .fwd_data(fwd_data), .fwd_mask(fwd_mask), .fwd_full(fwd_full),
    .fwd_partial(fwd_partial), .count(count), .empty(empty), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state: committed stores in program order plus a write-in-flight flag
  logic [E_W-1:0] exp_q[$];
  bit             m_busy;
  int             n_total, n_bad;

  // values sampled in the most recent cycle
  logic        s_ready, s_write, s_empty, s_full, s_part;
  logic [31:0] s_addr, s_wdata, s_fdata;
  logic [3:0]  s_wmask, s_fmask;
  logic [2:0]  s_count;

  function automatic logic [29:0] e_wa(input logic [E_W-1:0] e); return e[65:36]; endfunction
  function automatic logic [31:0] e_d (input logic [E_W-1:0] e); return e[35:4];  endfunction
  function automatic logic [3:0]  e_m (input logic [E_W-1:0] e); return e[3:0];   endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver: one clock cycle of stimulus, output check, and model update
  task automatic cycle(input logic ev, input logic [31:0] ea, input logic [31:0] ed,
                       input logic [3:0] em, input logic resp, input logic lv,
                       input logic [31:0] la, input logic [3:0] lr);
    int             sz;
    bit             coal_ok, e_ready, acc, pop, busy_n, e_full, e_part;
    logic [3:0]     fm;
    logic [31:0]    fd, dd;
    logic [E_W-1:0] y;
    @(negedge clk);
    enq_valid = ev; enq_addr = ea; enq_wdata = ed; enq_wmask = em;
    dmem_resp = resp; ld_valid = lv; ld_addr = la; ld_rmask = lr;
    #1;
    sz      = exp_q.size();
    coal_ok = COAL && (sz > 0) && (e_wa(exp_q[sz-1]) == ea[31:2]) && !(sz == 1 && m_busy);
    e_ready = (sz < DEPTH) || coal_ok;
    fm = '0; fd = '0;
    if (lv)
      foreach (exp_q[i])
        if (e_wa(exp_q[i]) == la[31:2])
          for (int b = 0; b < 4; b++)
            if (e_m(exp_q[i])[b]) begin
              fm[b] = 1'b1;
              dd = e_d(exp_q[i]);
              fd[8*b +: 8] = dd[8*b +: 8];
            end
    e_full = lv && ((lr & ~fm) == 4'd0) && (lr != 4'd0);
    e_part = lv && ((lr & fm) != 4'd0) && !e_full;

    s_ready = enq_ready; s_write = dmem_write; s_addr = dmem_addr; s_wdata = dmem_wdata;
    s_wmask = dmem_wmask; s_count = count; s_empty = empty; s_fdata = fwd_data;
    s_fmask = fwd_mask; s_full = fwd_full; s_part = fwd_partial;

    check("enq_ready",  s_ready, e_ready);
    check("dmem_write", s_write, m_busy);
    check("dmem_addr",  s_addr,  m_busy ? {e_wa(exp_q[0]), 2'b00} : 32'd0);
    check("dmem_wdata", s_wdata, m_busy ? e_d(exp_q[0]) : 32'd0);
    check("dmem_wmask", s_wmask, m_busy ? e_m(exp_q[0]) : 4'd0);
    check("count",      s_count, sz);
    check("empty",      s_empty, sz == 0);
    check("fwd_data",   s_fdata, fd);
    check("fwd_mask",   s_fmask, fm);
    check("fwd_full",   s_full,  e_full);
    check("fwd_part",   s_part,  e_part);

    @(posedge clk);
    acc    = ev && e_ready;
    pop    = m_busy && resp;
    busy_n = m_busy ? !resp : (sz > 0);
    if (pop) void'(exp_q.pop_front());
    if (acc) begin
      if (coal_ok) begin
        y = exp_q[exp_q.size()-1];
        dd = e_d(y);
        for (int b = 0; b < 4; b++) if (em[b]) dd[8*b +: 8] = ed[8*b +: 8];
        exp_q[exp_q.size()-1] = {e_wa(y), dd, e_m(y) | em};
      end else begin
        exp_q.push_back({ea[31:2], ed, em});
      end
    end
    m_busy = busy_n;
  endtask

  task automatic idle(input logic resp);
    cycle(1'b0, 32'd0, 32'd0, 4'd0, resp, 1'b0, 32'd0, 4'd0);
  endtask

  task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    cycle(1'b1, a, d, m, 1'b0, 1'b0, 32'd0, 4'd0);
  endtask

  task automatic lookup(input logic [31:0] a, input logic [3:0] r);
    cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, a, r);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (exp_q.size() > 0 || m_busy); i++) idle(1'b1);
    check("drained", exp_q.size() == 0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    enq_valid = 1'b0; dmem_resp = 1'b0; ld_valid = 1'b0;
    #1;
    check("rst_write", dmem_write, 1'b0);
    check("rst_count", count, 3'd0);
    check("rst_ready", enq_ready, 1'b1);
    check("rst_empty", empty, 1'b1);
    exp_q.delete();
    m_busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, la;
    n_total = 0; n_bad = 0; m_busy = 1'b0;
    rst = 1'b1;
    enq_valid = 1'b0; enq_addr = '0; enq_wdata = '0; enq_wmask = '0;
    dmem_resp = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_rmask = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // single store: write visible two cycles after acceptance
    enq(32'h100, 32'hAABBCCDD, 4'hF);
    idle(1'b0);
    check("tp1_no_write_yet", s_write, 1'b0);
    idle(1'b0);
    check("tp1_write", s_write, 1'b1);
    check("tp1_addr", s_addr, 32'h100);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);
    check("tp1_empty", s_empty, 1'b1);

    // fill to capacity; fifth store refused
    for (int i = 0; i < 5; i++) enq(32'h1000 + 32'(i) * 16, 32'hC0DE0000 + 32'(i), 4'hF);
    idle(1'b0);
    check("full_count", s_count, 3'd4);
    check("full_ready", s_ready, 1'b0);
    idle(1'b1);
    idle(1'b0);
    check("pop_count", s_count, 3'd3);
    check("pop_ready", s_ready, 1'b1);
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 32'h2000 + 32'(i) * 8, $urandom, 4'hF, 1'(i % 2), 1'b0, 32'd0, 4'd0);
    drain();

    // youngest-first per-lane forwarding
    enq(32'h200, 32'h11223344, 4'b0011);
    enq(32'h200, 32'h55667788, 4'b0110);
    lookup(32'h200, 4'b0111);
    check("fwd_data_tp", s_fdata, 32'h00667744);
    check("fwd_full_tp", s_full, 1'b1);
    drain();

    // partial coverage and a neighbouring word
    enq(32'h300, 32'h000000AB, 4'b0001);
    lookup(32'h300, 4'b0011);
    check("part_tp", s_part, 1'b1);
    check("part_full_tp", s_full, 1'b0);
    lookup(32'h304, 4'b0011);
    check("miss_mask_tp", s_fmask, 4'd0);
    drain();

    // same-word pair: merged or kept apart depending on build
    enq(32'h400, 32'h00000011, 4'b0001);
    enq(32'h400, 32'h00330000, 4'b0100);
    idle(1'b0);
    check("coal_count", s_count, COAL ? 3'd1 : 3'd2);
    check("coal_wmask", s_wmask, COAL ? 4'b0101 : 4'b0001);
    drain();

    // reset while a write is outstanding
    enq(32'h500, 32'hDEADBEEF, 4'hF);
    idle(1'b0);
    idle(1'b0);
    check("pre_rst_write", s_write, 1'b1);
    do_reset();
    idle(1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      ra = 32'h100 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3));
      la = 32'h100 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3));
      cycle($urandom_range(0, 9) < 6, ra, $urandom, 4'($urandom_range(1, 15)),
            $urandom_range(0, 9) < 4, 1'($urandom_range(0, 1)), la, 4'($urandom_range(0, 15)));
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
